serial_add_ctrl: RTL and testbench

//   Multi-cycle controller for wide additions. It reuses one SLICE-bit

---
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Multi-cycle wide adder: one SLICE-bit ripple slice is reused NSLICE times,
// least-significant slice first, with the carry held in a register between cycles.
module serial_add_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends on valid, and each side holds its payload
  // stable while its valid is high and the transfer has not yet occurred.

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [SLICE:0]   w_slice_res;
  logic [WIDTH-1:0] w_work_next;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);

  // The shared slice: full SLICE+1-bit result so the carry is never lost.
  always_comb begin
    w_slice_res = {1'b0, r_a[r_idx*SLICE +: SLICE]}
                + {1'b0, r_b[r_idx*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, r_carry};
    w_work_next = r_work;
    w_work_next[r_idx*SLICE +: SLICE] = w_slice_res[SLICE-1:0];
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = RUN;
      RUN:     if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_idx   <= '0;
        r_work  <= '0;
      end else if (r_state == RUN) begin
        r_work  <= w_work_next;
        r_carry <= w_slice_res[SLICE];
        if (w_last) begin
          r_idx  <= '0;
          r_sum  <= w_work_next;
          r_cout <= w_slice_res[SLICE];
        end else begin
          r_idx <= r_idx + IDXW'(1);
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == RUN);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed corner cases plus randomized traffic with
// random consumer backpressure, checked against a plain-arithmetic model.
module tb_serial_add_ctrl;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic [1:0]       state_dbg;

  serial_add_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [WIDTH:0] exp_q[$];
  int             acc_q[$];
  int             checks = 0;
  int             errors = 0;
  int             last_acc = 0;
  int             prev_acc = 0;
  logic           prev_ov = 1'b0;
  int             busy_run = 0;
  bit             bp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference model: the whole-word sum with one extra bit for the carry out.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc);
    int budget;
    @(posedge clk); #1;
    in_valid = 1'b1; a = xa; b = xb; cin = xc;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 60) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    exp_q.push_back(model(xa, xb, xc));
    acc_q.push_back(cyc);
    prev_acc = last_acc;
    last_acc = cyc;
    // Scramble the operand bus so a late sample would be visible.
    in_valid = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || !in_ready) && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    acc_q.delete();
  endtask

  // Random consumer backpressure when enabled.
  always @(posedge clk) begin
    if (bp_en) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_ov  = 1'b0;
      busy_run = 0;
    end else begin
      chk("state_onehot", 32'($countones({in_ready, busy, out_valid})), 32'd1);
      if (busy) busy_run++;
      if (out_valid && !prev_ov) begin
        chk("busy_cycles", 32'(busy_run), 32'(NSLICE));
        if (acc_q.size() == 0) begin
          chk("latency_no_accept", 32'(acc_q.size()), 32'd1);
        end else begin
          chk("latency", 32'(cyc - acc_q.pop_front()), 32'(NSLICE));
        end
      end
      if (!busy) busy_run = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          chk("sum", 32'(sum), 32'(exp_q[0][WIDTH-1:0]));
          chk("cout", 32'(cout), 32'(exp_q[0][WIDTH]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Directed: basic sum, full-ripple carries.
    send(16'h1234, 16'h4321, 1'b0);
    wait_drain("drain_basic");
    chk("basic_sum_const", 32'(sum), 32'h5555);
    chk("basic_cout_const", 32'(cout), 32'd0);
    send(16'hFFFF, 16'h0000, 1'b1);
    wait_drain("drain_ripple1");
    chk("ripple_sum_const", 32'(sum), 32'h0000);
    chk("ripple_cout_const", 32'(cout), 32'd1);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_drain("drain_ripple2");
    chk("max_sum_const", 32'(sum), 32'hFFFF);
    chk("max_cout_const", 32'(cout), 32'd1);

    // Mid-sim reset with in_valid high.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h5A5A; reset = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'h0000);
    chk("rst_cout", 32'(cout), 32'd0);
    flush_model();
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0; reset = 1'b0;

    // Backpressure in DONE while new operands are offered.
    out_ready = 1'b0;
    send(16'h0F0F, 16'h00F1, 1'b0);
    repeat (NSLICE + 1) @(negedge clk);
    chk("hold_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h1111; cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_sum_const", 32'(sum), 32'h1000);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_no_extra", 32'(out_valid), 32'd0);
    wait_drain("drain_hold");

    // Reset two cycles into RUN: result must be discarded.
    send(16'h00FF, 16'h0001, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_sum", 32'(sum), 32'h0000);
    chk("abort_state_idle", 32'(in_ready), 32'd1);
    flush_model();
    @(posedge clk); #1 reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_valid", 32'(out_valid), 32'd0);
    chk("abort_sum_after", 32'(sum), 32'h0000);

    // Reset while a result waits in DONE.
    out_ready = 1'b0;
    send(16'h0101, 16'h0202, 1'b0);
    repeat (NSLICE + 2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("done_rst_out_valid", 32'(out_valid), 32'd0);
    chk("done_rst_cout", 32'(cout), 32'd0);
    flush_model();
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;

    // Back-to-back accepts at minimum spacing.
    send(16'h0001, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    chk("accept_spacing", 32'(last_acc - prev_acc), 32'(NSLICE + 2));
    wait_drain("drain_b2b");
    chk("b2b_sum_const", 32'(sum), 32'h0000);
    chk("b2b_cout_const", 32'(cout), 32'd1);

    // Randomized traffic with random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain("drain_random");
    bp_en = 1'b0;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
